// File: rtl/hfg_rec_fetch.sv
// hfg_rec_fetch: fetches the four integral-image corners of up to eight Haar
// rectangles, one buffer read per cycle. It packs the corners into per-rectangle
// {D,C,B,A} buses and presents them, with masked sign bits, under a one-cycle
// oReady strobe.
module hfg_rec_fetch #(
    parameter int II_W   = 321,
    parameter int ADDR_W = 17,
    parameter int DATA_W = 21
) (
    input  logic                  iClk,
    input  logic                  iReset,
    input  logic                  iStart,
    input  logic [8:0]            iWinX,
    input  logic [7:0]            iWinY,
    input  logic [3:0]            iNumRec,
    input  logic [159:0]          iRecDesc,
    input  logic [7:0]            iSign,
    output logic                  oMemRd,
    output logic [ADDR_W-1:0]     oMemAddr,
    input  logic [DATA_W-1:0]     iMemData,
    output logic                  oBusy,
    output logic                  oReady,
    output logic [7:0]            oSign,
    output logic [4*DATA_W-1:0]   oRec4_0,
    output logic [4*DATA_W-1:0]   oRec4_1,
    output logic [4*DATA_W-1:0]   oRec4_2,
    output logic [4*DATA_W-1:0]   oRec4_3,
    output logic [4*DATA_W-1:0]   oRec4_4,
    output logic [4*DATA_W-1:0]   oRec4_5,
    output logic [4*DATA_W-1:0]   oRec4_6,
    output logic [4*DATA_W-1:0]   oRec4_7
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_DRAIN,
        S_DONE
    } state_e;

    state_e                         state_q, state_d;
    logic [8:0]                     win_x_q, win_x_d;
    logic [7:0]                     win_y_q, win_y_d;
    logic [3:0]                     num_q, num_d;
    logic [7:0][19:0]               desc_q, desc_d;
    logic [7:0]                     sign_lat_q, sign_lat_d;
    logic [7:0]                     sign_q, sign_d;
    logic [4:0]                     idx_q, idx_d;
    logic                           cap_vld_q, cap_vld_d;
    logic [4:0]                     cap_idx_q, cap_idx_d;
    logic [7:0][4*DATA_W-1:0]       rec_q, rec_d;

    logic [3:0]                     num_in;
    logic [7:0]                     sign_mask;
    logic [19:0]                    cur_desc;
    logic [5:0]                     col_off, row_off;
    logic [8:0]                     col_sum, row_sum;
    logic [ADDR_W-1:0]              mem_addr;
    logic [4:0]                     last_idx;
    logic [2:0]                     num_m1;

    // Clamp the requested rectangle count and build the sign mask for rectangles >= N.
    always_comb begin
        num_in    = (iNumRec > 4'd8) ? 4'd8 : iNumRec;
        sign_mask = '0;
        for (int k = 0; k < 8; k++) begin
            sign_mask[k] = (k < int'(num_in));
        end
    end

    // Address of the corner selected by idx_q: rect idx_q[4:2], corner idx_q[1:0] (A,B,C,D).
    always_comb begin
        cur_desc = desc_q[idx_q[4:2]];
        col_off  = {1'b0, cur_desc[4:0]} + (idx_q[0] ? {1'b0, cur_desc[14:10]} : 6'd0);
        row_off  = {1'b0, cur_desc[9:5]} + (idx_q[1] ? {1'b0, cur_desc[19:15]} : 6'd0);
        col_sum  = win_x_q + {3'b0, col_off};
        row_sum  = {1'b0, win_y_q} + {3'b0, row_off};
        mem_addr = ADDR_W'(row_sum) * ADDR_W'(II_W) + ADDR_W'(col_sum);
        num_m1   = num_q[2:0] - 3'd1;
        last_idx = {num_m1, 2'b11};
    end

    // Next-state logic: job acceptance, read sequencing and corner capture.
    always_comb begin
        // NOTE: every variable gets its hold value first so no path leaves it
        // unassigned; otherwise synthesis would infer a latch.
        state_d    = state_q;
        win_x_d    = win_x_q;
        win_y_d    = win_y_q;
        num_d      = num_q;
        desc_d     = desc_q;
        sign_lat_d = sign_lat_q;
        sign_d     = sign_q;
        idx_d      = idx_q;
        cap_vld_d  = 1'b0;
        cap_idx_d  = idx_q;
        rec_d      = rec_q;

        // Data for the read issued last cycle lands in its rectangle/corner field now.
        if (cap_vld_q) begin
            case (cap_idx_q[1:0])
                2'd0:    rec_d[cap_idx_q[4:2]][DATA_W-1:0]          = iMemData;
                2'd1:    rec_d[cap_idx_q[4:2]][2*DATA_W-1:DATA_W]   = iMemData;
                2'd2:    rec_d[cap_idx_q[4:2]][3*DATA_W-1:2*DATA_W] = iMemData;
                default: rec_d[cap_idx_q[4:2]][4*DATA_W-1:3*DATA_W] = iMemData;
            endcase
        end

        case (state_q)
            S_IDLE: begin
                if (iStart) begin
                    win_x_d    = iWinX;
                    win_y_d    = iWinY;
                    num_d      = num_in;
                    desc_d     = iRecDesc;
                    sign_lat_d = iSign & sign_mask;
                    sign_d     = '0;
                    rec_d      = '0;
                    idx_d      = '0;
                    state_d    = (num_in == 4'd0) ? S_DONE : S_ISSUE;
                end
            end
            S_ISSUE: begin
                cap_vld_d = 1'b1;
                idx_d     = idx_q + 5'd1;
                if (idx_q == last_idx) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                sign_d  = sign_lat_q;
                state_d = S_DONE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State register with synchronous reset; outputs and in-flight captures are cleared too.
    always_ff @(posedge iClk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge values regardless of statement order.
        if (iReset) begin
            state_q    <= S_IDLE;
            win_x_q    <= '0;
            win_y_q    <= '0;
            num_q      <= '0;
            desc_q     <= '0;
            sign_lat_q <= '0;
            sign_q     <= '0;
            idx_q      <= '0;
            cap_vld_q  <= 1'b0;
            cap_idx_q  <= '0;
            // NOTE: the rectangle buses are visible outputs that must read zero
            // after reset, so this storage is reset, unlike a plain data RAM.
            rec_q      <= '0;
        end else begin
            state_q    <= state_d;
            win_x_q    <= win_x_d;
            win_y_q    <= win_y_d;
            num_q      <= num_d;
            desc_q     <= desc_d;
            sign_lat_q <= sign_lat_d;
            sign_q     <= sign_d;
            idx_q      <= idx_d;
            cap_vld_q  <= cap_vld_d;
            cap_idx_q  <= cap_idx_d;
            rec_q      <= rec_d;
        end
    end

    assign oMemRd   = (state_q == S_ISSUE);
    assign oMemAddr = oMemRd ? mem_addr : '0;
    assign oBusy    = (state_q != S_IDLE);
    assign oReady   = (state_q == S_DONE);
    assign oSign    = sign_q;
    assign oRec4_0  = rec_q[0];
    assign oRec4_1  = rec_q[1];
    assign oRec4_2  = rec_q[2];
    assign oRec4_3  = rec_q[3];
    assign oRec4_4  = rec_q[4];
    assign oRec4_5  = rec_q[5];
    assign oRec4_6  = rec_q[6];
    assign oRec4_7  = rec_q[7];

endmodule

// File: tb/tb_hfg_rec_fetch.sv
// Bench for hfg_rec_fetch. Stimulus pushes expected reads and expected oReady
// results into queues. A negedge monitor pops them and compares whenever the
// DUT strobes oMemRd or oReady. The memory model returns the previous cycle's
// address.
module tb_hfg_rec_fetch;

    typedef struct {
        int           cyc;
        logic [16:0]  addr;
    } rd_exp_t;

    typedef struct {
        int               cyc;
        logic [7:0]       sign;
        logic [7:0][83:0] rec;
    } rdy_exp_t;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [8:0]        win_x;
    logic [7:0]        win_y;
    logic [3:0]        num_rec;
    logic [159:0]      rec_desc;
    logic [7:0]        sign_in;
    logic              mem_rd;
    logic [16:0]       mem_addr;
    logic [20:0]       mem_data;
    logic              busy;
    logic              ready;
    logic [7:0]        sign_out;
    logic [7:0][83:0]  rec_o;

    int       cyc = 0;
    int       checks = 0;
    int       errors = 0;
    int       busy_lo = 1;
    int       busy_hi = 0;
    int       next_free = 0;
    bit       mon_en = 1'b0;
    rd_exp_t  rd_q[$];
    rdy_exp_t rdy_q[$];

    hfg_rec_fetch #(.II_W(321), .ADDR_W(17), .DATA_W(21)) dut (
        .iClk(clk), .iReset(rst), .iStart(start), .iWinX(win_x), .iWinY(win_y),
        .iNumRec(num_rec), .iRecDesc(rec_desc), .iSign(sign_in),
        .oMemRd(mem_rd), .oMemAddr(mem_addr), .iMemData(mem_data),
        .oBusy(busy), .oReady(ready), .oSign(sign_out),
        .oRec4_0(rec_o[0]), .oRec4_1(rec_o[1]), .oRec4_2(rec_o[2]), .oRec4_3(rec_o[3]),
        .oRec4_4(rec_o[4]), .oRec4_5(rec_o[5]), .oRec4_6(rec_o[6]), .oRec4_7(rec_o[7])
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Integral-image buffer stand-in: each word equals the address read one cycle earlier.
    always @(posedge clk) mem_data <= {4'b0, mem_addr};

    task automatic check(input string name, input logic [83:0] act, input logic [83:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @cyc %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic wait_until(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    function automatic logic [19:0] pk(input int x, input int y, input int w, input int h);
        return {5'(h), 5'(w), 5'(y), 5'(x)};
    endfunction

    function automatic logic [16:0] model_addr(input logic [8:0] wx, input logic [7:0] wy,
                                               input logic [19:0] d, input int c);
        int x, y, w, h, col, row;
        x = int'(d[4:0]);  y = int'(d[9:5]);  w = int'(d[14:10]);  h = int'(d[19:15]);
        case (c)
            0:       begin col = x;     row = y;     end
            1:       begin col = x + w; row = y;     end
            2:       begin col = x;     row = y + h; end
            default: begin col = x + w; row = y + h; end
        endcase
        return 17'((int'(wy) + row) * 321 + int'(wx) + col);
    endfunction

    // Issue one job at the first free cycle and push its expected reads/result.
    task automatic issue(input logic [8:0] wx, input logic [7:0] wy, input logic [3:0] nrec,
                         input logic [7:0][19:0] desc, input logic [7:0] sgn,
                         input int max_reads, input bit expect_done,
                         input bit hand, input logic [83:0] hand_rec0, output int t0);
        int       n, nr, rdy;
        logic [16:0] a;
        rdy_exp_t e;
        wait_until(next_free);
        t0 = cyc;
        n  = (nrec > 4'd8) ? 8 : int'(nrec);
        e.rec  = '0;
        e.sign = '0;
        nr = 0;
        for (int k = 0; k < n; k++) begin
            e.sign[k] = sgn[k];
            for (int c = 0; c < 4; c++) begin
                if (hand && k == 0) a = hand_rec0[21*c +: 17];
                else                a = model_addr(wx, wy, desc[k], c);
                e.rec[k][21*c +: 21] = {4'b0, a};
                if (nr < max_reads) rd_q.push_back('{t0 + 1 + 4*k + c, a});
                nr++;
            end
        end
        rdy   = (n == 0) ? t0 + 1 : t0 + 4*n + 2;
        e.cyc = rdy;
        busy_lo = t0 + 1;
        if (expect_done) begin
            rdy_q.push_back(e);
            busy_hi   = rdy;
            next_free = rdy + 1;
        end else begin
            busy_hi   = t0 + max_reads;
            next_free = busy_hi + 2;
        end
        start = 1'b1; win_x = wx; win_y = wy; num_rec = nrec; rec_desc = desc; sign_in = sgn;
        @(negedge clk);
        start = 1'b0; win_x = ~wx; win_y = ~wy; num_rec = ~nrec; rec_desc = ~desc; sign_in = ~sgn;
    endtask

    // Monitor: compares every read strobe and every oReady against the scoreboard.
    always @(negedge clk) begin
        if (mon_en) begin
            check("busy", 84'(busy), 84'(cyc >= busy_lo && cyc <= busy_hi));
            if (mem_rd) begin
                if (rd_q.size() == 0) begin
                    check("rd_unexpected", 84'(mem_rd), 84'(0));
                end else begin
                    rd_exp_t r;
                    r = rd_q.pop_front();
                    check("rd_cycle", 84'(cyc), 84'(r.cyc));
                    check("rd_addr", 84'(mem_addr), 84'(r.addr));
                end
            end
            if (ready) begin
                if (rdy_q.size() == 0) begin
                    check("ready_unexpected", 84'(ready), 84'(0));
                end else begin
                    rdy_exp_t e;
                    e = rdy_q.pop_front();
                    check("ready_cycle", 84'(cyc), 84'(e.cyc));
                    check("sign", 84'(sign_out), 84'(e.sign));
                    for (int k = 0; k < 8; k++)
                        check($sformatf("rec%0d", k), rec_o[k], e.rec[k]);
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0][19:0] d;
        int t0, t1;
        rst = 1'b1; start = 1'b0; win_x = '0; win_y = '0; num_rec = '0;
        rec_desc = '0; sign_in = '0;
        repeat (3) @(negedge clk);
        check("rst_memrd", 84'(mem_rd), 84'(0));
        check("rst_addr", 84'(mem_addr), 84'(0));
        check("rst_busy", 84'(busy), 84'(0));
        check("rst_ready", 84'(ready), 84'(0));
        check("rst_sign", 84'(sign_out), 84'(0));
        for (int k = 0; k < 8; k++) check($sformatf("rst_rec%0d", k), rec_o[k], 84'(0));
        rst = 1'b0;
        mon_en = 1'b1;
        @(negedge clk);

        // Hand-computed single rectangle; unused descriptors hold junk.
        d = {8{20'hFFFFF}};
        d[0] = pk(2, 3, 4, 5);
        issue(9'd10, 8'd20, 4'd1, d, 8'hFF, 32, 1'b1, 1'b1,
              {21'd9004, 21'd9000, 21'd7399, 21'd7395}, t0);

        // Eight distinct rectangles, random window.
        for (int k = 0; k < 8; k++) d[k] = pk(3*k, 2*k + 1, k + 2, 9 - k);
        issue(9'($urandom_range(0, 200)), 8'($urandom_range(0, 150)), 4'd8, d, 8'hA5,
              32, 1'b1, 1'b0, '0, t0);

        // Empty job.
        issue(9'd40, 8'd40, 4'd0, d, 8'hFF, 32, 1'b1, 1'b0, '0, t0);

        // Count above eight clamps to eight.
        for (int k = 0; k < 8; k++) d[k] = pk(31 - k, k, k, k + 5);
        issue(9'd100, 8'd50, 4'd12, d, 8'h3C, 32, 1'b1, 1'b0, '0, t0);

        // iStart during a busy N=2 job is ignored; next job accepted at T0+11.
        d = {8{20'h0}};
        d[0] = pk(1, 2, 3, 4);
        d[1] = pk(6, 0, 10, 2);
        issue(9'd5, 8'd7, 4'd2, d, 8'hFF, 32, 1'b1, 1'b0, '0, t0);
        wait_until(t0 + 5);
        start = 1'b1; num_rec = 4'd1; win_x = 9'd300; win_y = 8'd200; rec_desc = '1; sign_in = 8'h00;
        wait_until(t0 + 6);
        start = 1'b0;
        d[2] = pk(9, 9, 9, 9);
        issue(9'd20, 8'd30, 4'd3, d, 8'h0F, 32, 1'b1, 1'b0, '0, t1);

        // Reset mid-job at T0+3 of an N=4 job.
        for (int k = 0; k < 8; k++) d[k] = pk(k, k, 2, 3);
        issue(9'd60, 8'd60, 4'd4, d, 8'hFF, 3, 1'b0, 1'b0, '0, t0);
        wait_until(t0 + 3);
        rst = 1'b1;
        wait_until(t0 + 4);
        rst = 1'b0;
        check("post_rst_memrd", 84'(mem_rd), 84'(0));
        check("post_rst_sign", 84'(sign_out), 84'(0));
        check("post_rst_rec0", rec_o[0], 84'(0));
        d[0] = pk(4, 4, 4, 4);
        issue(9'd15, 8'd25, 4'd1, d, 8'h01, 32, 1'b1, 1'b0, '0, t0);

        // Extreme corner: bottom-right word of the image, no 17-bit wrap.
        d[0] = pk(0, 0, 31, 31);
        issue(9'd289, 8'd210, 4'd1, d, 8'h01, 32, 1'b1, 1'b1,
              {21'd77681, 21'd77650, 21'd67730, 21'd67699}, t0);

        wait_until(next_free + 3);
        check("rd_left", 84'(rd_q.size()), 84'(0));
        check("ready_left", 84'(rdy_q.size()), 84'(0));
        mon_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
